// File: rtl/seletor_operador.sv
// Operator selector for the ULA: synchronizes, debounces and edge-detects three buttons,
// steps a 3-bit operator code and commits it on confirm. Debouncer enabled by SELETOR_OPERADOR_DEBOUNCE_EN.
module seletor_operador #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_prox,
    input  logic       btn_ant,
    input  logic       btn_conf,
    output logic [2:0] op,
    output logic [2:0] op_conf,
    output logic       conf_pulse,
    output logic       editando
);

    localparam int         NB     = 3;
    localparam logic [2:0] OP_MAX = 3'b110;

    if (DEBOUNCE_CYCLES < 2) begin : g_param_chk
        $error("seletor_operador: DEBOUNCE_CYCLES must be >= 2");
    end

    typedef enum logic {
        ST_EDIT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Bit order for all per-button vectors: [0] prox, [1] ant, [2] conf.
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] s1_q;
    logic [NB-1:0] s2_q;
    logic [NB-1:0] db_lvl;
    logic [NB-1:0] db_dly_q;
    logic [NB-1:0] pres;

    assign btn_raw = {btn_conf, btn_ant, btn_prox};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_dly_q <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            db_dly_q <= db_lvl;
        end
    end

`ifdef SELETOR_OPERADOR_DEBOUNCE_EN
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    db_q;
    logic [NB-1:0]    db_d;

    // Counter only runs while the synchronized input disagrees with the debounced level.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_lvl = db_q;
`else
    assign db_lvl = s2_q;
`endif

    assign pres = db_lvl & ~db_dly_q;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] op_conf_q, op_conf_d;
    logic       conf_pulse_q, conf_pulse_d;
    logic       pres_prox, pres_ant, pres_conf;

    assign pres_prox = pres[0];
    assign pres_ant  = pres[1];
    assign pres_conf = pres[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EDIT;
            op_q         <= 3'b000;
            op_conf_q    <= 3'b000;
            conf_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            op_conf_q    <= op_conf_d;
            conf_pulse_q <= conf_pulse_d;
        end
    end

    // Confirm outranks stepping; next+previous together cancel out.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        op_conf_d    = op_conf_q;
        conf_pulse_d = 1'b0;
        unique case (state_q)
            ST_EDIT: begin
                if (pres_conf) begin
                    op_conf_d    = op_q;
                    conf_pulse_d = 1'b1;
                    state_d      = ST_LOCK;
                end else if (pres_prox && !pres_ant) begin
                    op_d = (op_q == OP_MAX) ? 3'b000 : op_q + 3'd1;
                end else if (pres_ant && !pres_prox) begin
                    op_d = (op_q == 3'b000) ? OP_MAX : op_q - 3'd1;
                end
            end
            ST_LOCK: begin
                if (pres_prox || pres_ant) begin
                    state_d = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    assign op         = op_q;
    assign op_conf    = op_conf_q;
    assign conf_pulse = conf_pulse_q;
    assign editando   = (state_q == ST_EDIT);

endmodule
